// File: rtl/axil_mem_tester_pkg.sv
// Shared types and helpers for the AXI4-Lite memory tester.
//   state_t    : controller states
//   LFSR_TAPS  : 32-bit Galois LFSR feedback taps
//   RESP_OKAY  : AXI OKAY response code
//   lfsr_next(): one Galois LFSR step
package axil_mem_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-Lite interface bundle, all five channels.
//   mst : manager view
//   slv : subordinate view
interface taxi_axil_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport mst (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slv (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_mem_tester_pat.sv
// Test pattern generator: 32-bit Galois LFSR replicated to DATA_W.
//   clk, rst_n : clock, async active-low reset (pattern resets to 0)
//   load       : load LFSR_SEED (a zero seed is replaced by 1)
//   advance    : step the LFSR once
//   pattern    : current pattern, DATA_W bits
module axil_mem_tester_pat
  import axil_mem_tester_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [31:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign pattern = {(DATA_W / 32){lfsr}};

endmodule

// File: rtl/axil_mem_tester.sv
// AXI4-Lite memory traffic generator and checker.
// Writes LFSR patterns over an address window, reads them back, compares.
//   clk, rst_n      : clock, async active-low reset
//   axi_if          : AXI4-Lite manager port
//   start           : run request (honoured in IDLE/DONE only)
//   busy, done      : run in progress / run finished (level)
//   pass            : run finished with no errors and no timeout
//   timeout         : run aborted by a stalled handshake
//   err_cnt         : saturating mismatch + bad-response count
//   first_err_addr  : address of the first error
//   first_err_data  : rdata of the first error (0 for a write response error)
//   max_rd_lat      : longest AR->R handshake latency (stats build only)
//   run_cycles      : cycles from start to done (stats build only)
// Optional: define AXIL_MEM_TESTER_STATS_EN to build the statistics counters.
module axil_mem_tester
  import axil_mem_tester_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_XFERS   = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       ADDR_STRIDE = DATA_W / 8,
  parameter int unsigned       MODE        = 0,
  parameter logic [31:0]       LFSR_SEED   = 32'hACE1_0001,
  parameter int unsigned       TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  taxi_axil_if.mst          axi_if,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0]       max_rd_lat,
  output logic [31:0]       run_cycles
);

  state_t state, state_next;

  logic [ADDR_W-1:0]   addr;
  logic [15:0]         idx;
  logic [31:0]         tmo_cnt;
  logic [DATA_W-1:0]   pattern;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic              start_ok, wait_state, last;
  logic              b_fire, ar_fire, r_fire;
  logic              load_seed, advance, addr_base, addr_step;
  logic              log_err, tmo_hit, enter_done;
  logic [DATA_W-1:0] err_data;

  axil_mem_tester_pat #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_seed),
    .advance (advance),
    .pattern (pattern)
  );

  assign b_fire  = axi_if.bvalid & bready_q;
  assign ar_fire = arvalid_q & axi_if.arready;
  assign r_fire  = axi_if.rvalid & rready_q;

  always_comb begin
    state_next = state;
    load_seed  = 1'b0;
    advance    = 1'b0;
    addr_base  = 1'b0;
    addr_step  = 1'b0;
    log_err    = 1'b0;
    err_data   = '0;
    tmo_hit    = 1'b0;
    start_ok   = 1'b0;
    wait_state = (state == WR_REQ) || (state == WR_RESP) ||
                 (state == RD_REQ) || (state == RD_RESP);
    last       = (idx == 16'(NUM_XFERS - 1));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          load_seed  = 1'b1;
          addr_base  = 1'b1;
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        // each valid drops on its own handshake; leave once neither is pending
        if ((!awvalid_q || axi_if.awready) && (!wvalid_q || axi_if.wready)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_fire) begin
          log_err = (axi_if.bresp != RESP_OKAY);
          if (MODE == 0) begin
            state_next = RD_REQ;
          end else if (last) begin
            load_seed  = 1'b1;
            addr_base  = 1'b1;
            state_next = RD_REQ;
          end else begin
            advance    = 1'b1;
            addr_step  = 1'b1;
            state_next = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (ar_fire) begin
          state_next = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_fire) begin
          if ((axi_if.rdata != pattern) || (axi_if.rresp != RESP_OKAY)) begin
            log_err  = 1'b1;
            err_data = axi_if.rdata;
          end
          advance   = 1'b1;
          addr_step = 1'b1;
          if (last) begin
            state_next = DONE;
          end else if (MODE == 0) begin
            state_next = WR_REQ;
          end else begin
            state_next = RD_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // a handshake completing on the final allowed cycle still wins
    if (wait_state && (state_next == state) && (tmo_cnt == 32'(TIMEOUT - 1))) begin
      tmo_hit    = 1'b1;
      state_next = DONE;
    end

    enter_done = (state_next == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt        <= '0;
      idx            <= '0;
      addr           <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      wstrb_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      tmo_cnt <= ((state_next != state) || !wait_state) ? '0 : tmo_cnt + 32'd1;

      if (addr_base) begin
        idx  <= '0;
        addr <= BASE_ADDR;
      end else if (addr_step) begin
        idx  <= idx + 16'd1;
        addr <= addr + ADDR_W'(ADDR_STRIDE);
      end

      awvalid_q <= (state_next == WR_REQ) &&
                   ((state != WR_REQ) || (awvalid_q && !axi_if.awready));
      wvalid_q  <= (state_next == WR_REQ) &&
                   ((state != WR_REQ) || (wvalid_q && !axi_if.wready));
      bready_q  <= (state_next == WR_RESP);
      arvalid_q <= (state_next == RD_REQ);
      rready_q  <= (state_next == RD_RESP);

      if (start_ok) begin
        wstrb_q        <= '1;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else begin
        if (log_err) begin
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
          if (err_cnt == '0) begin
            first_err_addr <= addr;
            first_err_data <= err_data;
          end
        end
        if (enter_done) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          timeout <= tmo_hit;
          pass    <= !tmo_hit && (err_cnt == '0) && !log_err;
        end
      end
    end
  end

  assign axi_if.awaddr  = addr;
  assign axi_if.awprot  = '0;
  assign axi_if.awvalid = awvalid_q;
  assign axi_if.wdata   = pattern;
  assign axi_if.wstrb   = wstrb_q;
  assign axi_if.wvalid  = wvalid_q;
  assign axi_if.bready  = bready_q;
  assign axi_if.araddr  = addr;
  assign axi_if.arprot  = '0;
  assign axi_if.arvalid = arvalid_q;
  assign axi_if.rready  = rready_q;

`ifdef AXIL_MEM_TESTER_STATS_EN
  logic [15:0] max_lat_q;
  logic [31:0] run_q;
  logic [15:0] cur_lat;

  // tmo_cnt counts RD_RESP cycles before the R handshake; latency includes that cycle
  always_comb begin
    cur_lat = 16'hFFFF;
    if (tmo_cnt < 32'h0000_FFFF) begin
      cur_lat = tmo_cnt[15:0] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_lat_q <= '0;
      run_q     <= '0;
    end else if (start_ok) begin
      max_lat_q <= '0;
      run_q     <= '0;
    end else begin
      if ((state == RD_RESP) && r_fire && (cur_lat > max_lat_q)) begin
        max_lat_q <= cur_lat;
      end
      if (busy && (run_q != '1)) begin
        run_q <= run_q + 32'd1;
      end
    end
  end

  assign max_rd_lat = max_lat_q;
  assign run_cycles = run_q;
`else
  assign max_rd_lat = '0;
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_axil_mem_tester.sv
// Bench for axil_mem_tester: MODE 0 and MODE 1 instances, each with a small
// RAM subordinate model; expected write/read traffic is queued at start.
module tb_axil_mem_tester;

  localparam int unsigned N    = 4;
  localparam logic [31:0] BASE = 32'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  logic [31:0] pat [N];

  // ---------------- DUT 0: interleaved ----------------
  taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  logic        start0 = 1'b0;
  logic        busy0, done0, pass0, tmo0;
  logic [15:0] err0, lat0;
  logic [31:0] fea0, fed0, run0;

  axil_mem_tester #(
    .ADDR_W(32), .DATA_W(32), .NUM_XFERS(N), .BASE_ADDR(BASE),
    .MODE(0), .LFSR_SEED(32'hACE1_0001), .TIMEOUT(64)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .axi_if(if0), .start(start0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
    .err_cnt(err0), .first_err_addr(fea0), .first_err_data(fed0),
    .max_rd_lat(lat0), .run_cycles(run0)
  );

  // ---------------- DUT 1: block ----------------
  taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  logic        start1 = 1'b0;
  logic        busy1, done1, pass1, tmo1;
  logic [15:0] err1, lat1;
  logic [31:0] fea1, fed1, run1;

  axil_mem_tester #(
    .ADDR_W(32), .DATA_W(32), .NUM_XFERS(N), .BASE_ADDR(BASE),
    .MODE(1), .LFSR_SEED(32'hACE1_0001), .TIMEOUT(64)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .axi_if(if1), .start(start1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
    .err_cnt(err1), .first_err_addr(fea1), .first_err_data(fed1),
    .max_rd_lat(lat1), .run_cycles(run1)
  );

  // ---------------- subordinate model 0 ----------------
  logic        rnd_mode = 1'b1;
  logic [31:0] rnd = 32'h0;
  logic        hang_b = 1'b0;
  logic        flip = 1'b0;
  int unsigned rd_wait = 0;

  logic        s0_bvalid, s0_rvalid;
  logic [31:0] s0_rdata;
  int unsigned s0_cnt;
  logic [31:0] mem0 [64];

  assign if0.awready = rnd_mode ? rnd[0] : 1'b1;
  assign if0.wready  = rnd_mode ? rnd[1] : 1'b1;
  assign if0.arready = rnd_mode ? rnd[2] : 1'b1;
  assign if0.bvalid  = rnd_mode ? rnd[3] : s0_bvalid;
  assign if0.bresp   = rnd_mode ? rnd[5:4] : 2'b00;
  assign if0.rvalid  = rnd_mode ? rnd[6] : s0_rvalid;
  assign if0.rdata   = rnd_mode ? rnd : s0_rdata;
  assign if0.rresp   = rnd_mode ? rnd[9:8] : 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_bvalid <= 1'b0;
      s0_rvalid <= 1'b0;
      s0_rdata  <= '0;
      s0_cnt    <= 0;
    end else begin
      if (s0_bvalid && if0.bready) s0_bvalid <= 1'b0;
      if (if0.awvalid && if0.awready && if0.wvalid && if0.wready) begin
        mem0[if0.awaddr[7:2]] <= if0.wdata;
        if (!hang_b) s0_bvalid <= 1'b1;
      end
      if (s0_rvalid && if0.rready) s0_rvalid <= 1'b0;
      if (if0.arvalid && if0.arready) begin
        s0_rdata <= mem0[if0.araddr[7:2]] ^ ((flip && if0.araddr == 32'h108) ? 32'h1 : 32'h0);
        if (rd_wait == 0) s0_rvalid <= 1'b1;
        else s0_cnt <= rd_wait;
      end else if (s0_cnt != 0) begin
        s0_cnt <= s0_cnt - 1;
        if (s0_cnt == 1) s0_rvalid <= 1'b1;
      end
    end
  end

  // ---------------- subordinate model 1 ----------------
  logic        s1_bvalid, s1_rvalid;
  logic [31:0] s1_rdata;
  logic [31:0] mem1 [64];

  assign if1.awready = 1'b1;
  assign if1.wready  = 1'b1;
  assign if1.arready = 1'b1;
  assign if1.bvalid  = s1_bvalid;
  assign if1.bresp   = 2'b00;
  assign if1.rvalid  = s1_rvalid;
  assign if1.rdata   = s1_rdata;
  assign if1.rresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bvalid <= 1'b0;
      s1_rvalid <= 1'b0;
      s1_rdata  <= '0;
    end else begin
      if (s1_bvalid && if1.bready) s1_bvalid <= 1'b0;
      if (if1.awvalid && if1.wvalid) begin
        mem1[if1.awaddr[7:2]] <= if1.wdata;
        s1_bvalid <= 1'b1;
      end
      if (s1_rvalid && if1.rready) s1_rvalid <= 1'b0;
      if (if1.arvalid) begin
        s1_rdata  <= mem1[if1.araddr[7:2]];
        s1_rvalid <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        aw_q[$];
  exp_t        ar_q[$];
  logic [31:0] last_wr_addr = '0;
  int unsigned w_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !rnd_mode) begin
      if (if0.awvalid && if0.awready) begin
        w_cyc        = cyc + 1;
        last_wr_addr = if0.awaddr;
        check("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) begin
          e = aw_q.pop_front();
          check("awaddr", if0.awaddr, e.addr);
          check("wdata", if0.wdata, e.data);
          check("w_with_aw", if0.wvalid && if0.wready, 1);
        end
      end
      if (if0.arvalid && if0.arready) begin
        check("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) begin
          e = ar_q.pop_front();
          check("araddr", if0.araddr, e.addr);
        end
        check("rd_follows_wr", if0.araddr, last_wr_addr);
      end
    end
  end

  int unsigned aw_cnt1 = 0;
  int unsigned ar_cnt1 = 0;
  int unsigned aw_before_ar1 = 0;

  always @(negedge clk) begin
    if (rst_n && !rnd_mode) begin
      if (if1.awvalid && if1.awready) begin
        check("m1_awaddr", if1.awaddr, BASE + 4 * aw_cnt1);
        check("m1_wdata", if1.wdata, (aw_cnt1 < N) ? pat[aw_cnt1] : 32'h0);
        aw_cnt1++;
      end
      if (if1.arvalid && if1.arready) begin
        if (ar_cnt1 == 0) aw_before_ar1 = aw_cnt1;
        check("m1_araddr", if1.araddr, BASE + 4 * ar_cnt1);
        ar_cnt1++;
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  int unsigned start_cyc = 0;

  task automatic run_start(input bit which);
    exp_t e;
    if (!which) begin
      aw_q.delete();
      ar_q.delete();
      for (int i = 0; i < N; i++) begin
        e.addr = BASE + 4 * i;
        e.data = pat[i];
        aw_q.push_back(e);
        ar_q.push_back(e);
      end
    end
    @(negedge clk);
    if (which) start1 = 1'b1;
    else start0 = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int unsigned bound, output int unsigned dcyc);
    int unsigned k;
    k = 0;
    while (((which ? done1 : done0) == 1'b0) && (k < bound)) begin
      @(negedge clk);
      k++;
    end
    check("done_in_bound", which ? done1 : done0, 1);
    dcyc = cyc;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned dcyc;
    int unsigned k;

    pat[0] = 32'hACE1_0001;
    for (int i = 1; i < N; i++) pat[i] = model_step(pat[i-1]);

    // reset with random subordinate activity
    repeat (5) begin
      @(negedge clk);
      rnd = $urandom;
    end
    check("rst_valids0", {if0.awvalid, if0.wvalid, if0.arvalid, if0.bready, if0.rready}, 0);
    check("rst_valids1", {if1.awvalid, if1.wvalid, if1.arvalid, if1.bready, if1.rready}, 0);
    check("rst_status0", {busy0, done0, pass0, tmo0}, 0);
    check("rst_err0", err0, 0);
    check("rst_first_err", {fea0, fed0}, 0);
    check("rst_axi_data", {if0.awaddr, if0.wdata, if0.wstrb}, 0);
    rnd_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // normal interleaved run with a start pulse mid-run
    run_start(0);
    check("busy_after_start", busy0, 1);
    check("aw_w_after_start", {if0.awvalid, if0.wvalid}, 2'b11);
    check("wstrb", if0.wstrb, 4'hF);
    repeat (5) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 200, dcyc);
    check("run_len", dcyc - start_cyc, 16);
    check("pass_ok", pass0, 1);
    check("err_ok", err0, 0);
    check("tmo_ok", tmo0, 0);
    check("aw_q_drained", aw_q.size(), 0);
    check("ar_q_drained", ar_q.size(), 0);
`ifdef AXIL_MEM_TESTER_STATS_EN
    check("stat_lat_zw", lat0, 1);
    check("stat_run_zw", run0, 16);
`else
    check("stat_lat_tied", lat0, 0);
    check("stat_run_tied", run0, 0);
`endif

    // corrupted read at 0x108
    flip = 1'b1;
    run_start(0);
    wait_done(0, 200, dcyc);
    flip = 1'b0;
    check("fault_err_cnt", err0, 1);
    check("fault_addr", fea0, 32'h108);
    check("fault_data", fed0, pat[2] ^ 32'h1);
    check("fault_pass", pass0, 0);
    check("fault_tmo", tmo0, 0);

    // slow read responses
    rd_wait = 3;
    run_start(0);
    wait_done(0, 300, dcyc);
    rd_wait = 0;
    check("slow_run_len", dcyc - start_cyc, 28);
    check("slow_pass", pass0, 1);
`ifdef AXIL_MEM_TESTER_STATS_EN
    check("stat_lat_slow", lat0, 4);
    check("stat_run_slow", run0, 28);
`endif

    // hung write response
    hang_b = 1'b1;
    run_start(0);
    wait_done(0, 300, dcyc);
    hang_b = 1'b0;
    check("hang_delay", dcyc - w_cyc, 64);
    check("hang_tmo", tmo0, 1);
    check("hang_pass", pass0, 0);
    check("hang_busy", busy0, 0);
    @(negedge clk);
    check("hang_readies", {if0.bready, if0.awvalid, if0.wvalid, if0.arvalid, if0.rready}, 0);

    // reset during a read
    run_start(0);
    k = 0;
    while (!if0.arvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ar_seen", if0.arvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ar", {if0.arvalid, if0.rready}, 0);
    check("rst_mid_busy", busy0, 0);
    aw_q.delete();
    ar_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_start(0);
    wait_done(0, 200, dcyc);
    check("rerun_len", dcyc - start_cyc, 16);
    check("rerun_pass", pass0, 1);
    check("rerun_q", aw_q.size() + ar_q.size(), 0);

    // block mode
    run_start(1);
    wait_done(1, 200, dcyc);
    check("m1_run_len", dcyc - start_cyc, 16);
    check("m1_aw_before_ar", aw_before_ar1, N);
    check("m1_reads", ar_cnt1, N);
    check("m1_pass", pass1, 1);
    check("m1_err", err1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
